// File: rtl/chaser_step_ctrl.sv
// Step and direction control for the 16-position LED chaser: debounces three
// push-buttons and drives a clock-enable style step strobe at one of four speeds.
module chaser_step_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_speed_n,
    input  logic       key_pause_n,
    input  logic       key_dir_n,
    output logic       step,
    output logic       dir,
    output logic       running,
    output logic [1:0] speed_sel
);

    localparam int CNT_W = $clog2(CLK_HZ);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_RUN,
        ST_PAUSE
    } state_t;

    logic [2:0] w_key_raw;
    logic [2:0] w_press;

    assign w_key_raw = {key_dir_n, key_pause_n, key_speed_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic            r_sync1;
            logic            r_sync2;
            logic [DB_W-1:0] r_db_cnt;
            logic            r_deb;
            logic            r_deb_d;
            logic            r_deb_dd;
            logic            r_press;

            // Press is detected two stages behind the debounced level so the
            // pulse lands D+3 cycles after the first low sample.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync1  <= 1'b1;
                    r_sync2  <= 1'b1;
                    r_db_cnt <= '0;
                    r_deb    <= 1'b1;
                    r_deb_d  <= 1'b1;
                    r_deb_dd <= 1'b1;
                    r_press  <= 1'b0;
                end else begin
                    r_sync1  <= w_key_raw[gi];
                    r_sync2  <= r_sync1;
                    r_deb_d  <= r_deb;
                    r_deb_dd <= r_deb_d;
                    r_press  <= r_deb_dd & ~r_deb_d;
                    if (r_sync2 == r_deb) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_deb    <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    logic w_speed_press;
    logic w_pause_press;
    logic w_dir_press;

    assign w_speed_press = w_press[0];
    assign w_pause_press = w_press[1];
    assign w_dir_press   = w_press[2];

    // Terminal count for each speed level: (CLK_HZ >> level) - 1.
    logic [CNT_W-1:0] w_last [4];
    generate
        for (gi = 0; gi < 4; gi++) begin : g_last
            assign w_last[gi] = CNT_W'((CLK_HZ >> gi) - 1);
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_speed;
    logic             r_dir;
    logic             r_step;
    logic             r_running;
    logic             w_term;

    assign w_term = (r_cnt == w_last[r_speed]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_speed   <= 2'd0;
            r_dir     <= 1'b0;
            r_step    <= 1'b0;
            r_running <= 1'b1;
        end else begin
            r_step <= 1'b0;
            if (w_dir_press) begin
                r_dir <= ~r_dir;
            end
            // A speed change restarts the period and swallows any step due now.
            if (w_speed_press) begin
                r_speed <= r_speed + 2'd1;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                if (w_term) begin
                    r_cnt  <= '0;
                    r_step <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            case (r_state)
                ST_RUN: begin
                    if (w_pause_press) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_press) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_running <= 1'b1;
                end
            endcase
        end
    end

    assign step      = r_step;
    assign dir       = r_dir;
    assign running   = r_running;
    assign speed_sel = r_speed;

endmodule

// File: tb/tb_chaser_step_ctrl.sv
// Bench for chaser_step_ctrl: directed test-plan steps plus random key activity,
// every cycle compared against a history-based behavioural model.
module tb_chaser_step_ctrl;

    localparam int HZ = 16;
    localparam int DB = 4;
    localparam int HL = DB + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_speed_n = 1'b1;
    logic       key_pause_n = 1'b1;
    logic       key_dir_n = 1'b1;
    logic       step;
    logic       dir;
    logic       running;
    logic [1:0] speed_sel;

    chaser_step_ctrl #(
        .CLK_HZ(HZ),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_speed_n(key_speed_n),
        .key_pause_n(key_pause_n),
        .key_dir_n  (key_dir_n),
        .step       (step),
        .dir        (dir),
        .running    (running),
        .speed_sel  (speed_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: raw sample history per key, accepted key level, and press
    // actions waiting to take effect three edges after acceptance.
    bit m_hist [3][HL];
    bit m_deb  [3];
    bit m_fl   [3][3];
    bit m_run;
    bit m_dir;
    bit m_step;
    int m_cnt;
    int m_spd;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < HL; i++) m_hist[k][i] = 1'b1;
            for (int i = 0; i < 3; i++) m_fl[k][i] = 1'b0;
            m_deb[k] = 1'b1;
        end
        m_run = 1'b1; m_dir = 1'b0; m_step = 1'b0; m_cnt = 0; m_spd = 0;
    endtask

    task automatic model_edge();
        bit raw [3];
        bit act [3];
        int period;
        raw[0] = key_speed_n; raw[1] = key_pause_n; raw[2] = key_dir_n;
        for (int k = 0; k < 3; k++) begin
            bit all_diff;
            bit fp;
            for (int i = 0; i < HL - 1; i++) m_hist[k][i] = m_hist[k][i+1];
            m_hist[k][HL-1] = raw[k];
            // The level is accepted once DB consecutive synchronized samples
            // (raw delayed two edges) disagree with the current level.
            all_diff = 1'b1;
            for (int i = 0; i <= HL - 3; i++)
                if (m_hist[k][i] == m_deb[k]) all_diff = 1'b0;
            fp = 1'b0;
            if (all_diff) begin
                m_deb[k] = ~m_deb[k];
                fp = (m_deb[k] == 1'b0);
            end
            act[k] = m_fl[k][0];
            m_fl[k][0] = m_fl[k][1];
            m_fl[k][1] = m_fl[k][2];
            m_fl[k][2] = fp;
        end
        period = HZ >> m_spd;
        m_step = m_run && !act[0] && (m_cnt == period - 1);
        if (act[0]) begin
            m_cnt = 0;
            m_spd = (m_spd + 1) % 4;
        end else if (m_run) begin
            m_cnt = (m_cnt == period - 1) ? 0 : m_cnt + 1;
        end
        if (act[1]) m_run = ~m_run;
        if (act[2]) m_dir = ~m_dir;
    endtask

    task automatic check_outputs();
        chk("step", step, int'(m_step));
        chk("dir", dir, int'(m_dir));
        chk("running", running, int'(m_run));
        chk("speed_sel", speed_sel, m_spd);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset) model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic apply_reset(input int hold);
        reset = 1'b1;
        key_speed_n = 1'b1; key_pause_n = 1'b1; key_dir_n = 1'b1;
        model_reset();
        #1;
        check_outputs();
        repeat (hold) tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic set_key(input int k, input bit v);
        case (k)
            0: key_speed_n = v;
            1: key_pause_n = v;
            default: key_dir_n = v;
        endcase
    endtask

    task automatic press(input int k, input int hold, input int gap);
        set_key(k, 1'b0);
        repeat (hold) tick();
        set_key(k, 1'b1);
        repeat (gap) tick();
    endtask

    initial begin
        int e;
        int nsteps;
        @(negedge clk);
        apply_reset(3);

        // 1: free run at speed 0
        while (cyc < 48) begin
            tick();
            if (cyc == 16 || cyc == 32 || cyc == 48) chk("t1_step", step, 1);
        end

        // 2: speed press, latency 8 cycles from first low sample
        e = cyc + 1;
        key_speed_n = 1'b0;
        while (cyc < e + 7) tick();
        chk("t2_speed_pre", speed_sel, 0);
        tick();
        chk("t2_speed_post", speed_sel, 1);
        while (cyc < e + 19) tick();
        key_speed_n = 1'b1;
        repeat (30) tick();
        for (int n = 2; n <= 4; n++) begin
            press(0, 20, 30);
            chk("t2_speed_cycle", speed_sel, n % 4);
        end

        // 3: bounce is rejected, clean press pauses, second press resumes
        press(1, 3, 1);
        press(1, 3, 15);
        chk("t3_bounce_running", running, 1);
        press(1, 12, 0);
        chk("t3_paused", running, 0);
        nsteps = 0;
        repeat (100) begin
            tick();
            if (step === 1'b1) nsteps++;
        end
        chk("t3_no_step_paused", nsteps, 0);
        press(1, 12, 40);
        chk("t3_resumed", running, 1);

        // 4: speed pulse lands on the terminal-count cycle
        apply_reset(2);
        while (cyc < 40) begin
            key_speed_n = !(cyc >= 7 && cyc < 27);
            tick();
            if (cyc == 16) begin
                chk("t4_suppressed", step, 0);
                chk("t4_speed", speed_sel, 1);
            end
            if (cyc == 24) chk("t4_next_step", step, 1);
        end

        // 5: direction press coinciding with a step, then 6: reset mid-period
        apply_reset(2);
        while (cyc < 41) begin
            key_dir_n   = !(cyc >= 8 && cyc < 28);
            key_pause_n = !(cyc >= 39);
            tick();
            if (cyc == 16) begin
                chk("t5_step", step, 1);
                chk("t5_dir_old", dir, 0);
            end
            if (cyc == 17) begin
                chk("t5_dir_new", dir, 1);
                chk("t5_step_low", step, 0);
            end
            if (cyc == 32) chk("t5_spacing", step, 1);
        end
        chk("t6_dir_before", dir, 1);
        apply_reset(2);
        chk("t6_dir_reset", dir, 0);
        while (cyc < 40) begin
            tick();
            if (cyc == 16) chk("t6_first_step", step, 1);
        end
        chk("t6_no_pause", running, 1);

        // Random key activity, bounces and occasional resets
        repeat (40) begin
            int k;
            k = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) apply_reset($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3))
                    press(k, $urandom_range(1, DB - 1), $urandom_range(1, 2));
            end else begin
                press(k, $urandom_range(DB + 2, 12), 0);
            end
            repeat ($urandom_range(2, 20)) tick();
        end
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
